// File: rtl/hdlc_line_monitor_if.sv
// rtl/hdlc_line_monitor_if.sv - line/status inputs and counter/error outputs of the HDLC line monitor
interface hdlc_line_monitor_if #(
  parameter int CNT_W = 16
);
  logic             MonEN;
  logic             Clr;
  logic             Rx;
  logic             Rx_ValidFrame;
  logic             Rx_FlagDetect;
  logic             Rx_AbortDetect;
  logic [CNT_W-1:0] FlagCnt;
  logic [CNT_W-1:0] AbortCnt;
  logic [CNT_W-1:0] StuffCnt;
  logic [CNT_W-1:0] ErrCnt;
  logic             Err;
  logic [2:0]       ErrCode;
  logic [1:0]       LineState;

  modport master (
    output MonEN, Clr, Rx, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect,
    input  FlagCnt, AbortCnt, StuffCnt, ErrCnt, Err, ErrCode, LineState
  );

  modport slave (
    input  MonEN, Clr, Rx, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect,
    output FlagCnt, AbortCnt, StuffCnt, ErrCnt, Err, ErrCode, LineState
  );
endinterface

// File: rtl/hdlc_line_monitor.sv
// rtl/hdlc_line_monitor.sv - HDLC line monitor checking flag/abort detect status; optional idle check via HDLC_MON_IDLE_CHECK_EN
module hdlc_line_monitor #(
  parameter int CNT_W     = 16,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 2,
  parameter int IDLE_LEN  = 15
) (
  input  logic                Clk,
  input  logic                Rst,
  hdlc_line_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLAG  = 2'd1,
    ST_FRAME = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam logic [4:0] IDLE_MAX = 5'(IDLE_LEN);

  state_e                 state_q, state_d;
  logic [7:0]             hist_q, hist_d;
  logic [4:0]             ones_q, ones_d;
  logic [FLAG_LAT-1:0]    fpipe_q, fpipe_d;
  logic [ABORT_LAT-1:0]   apipe_q, apipe_d;
  logic [CNT_W-1:0]       flag_cnt_q, flag_cnt_d;
  logic [CNT_W-1:0]       abort_cnt_q, abort_cnt_d;
  logic [CNT_W-1:0]       stuff_cnt_q, stuff_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic                   err_q, err_d;
  logic [2:0]             err_code_q, err_code_d;

  logic [7:0] window;
  logic       flag_ev, abort_ev, stuff_ev;
  logic       miss_flag, spur_flag, miss_abort, spur_abort, idle_err;

  // Window covers the last seven history bits plus the bit on the line this cycle.
  assign window   = {hist_q[6:0], mon.Rx};
  assign flag_ev  = mon.MonEN && (window == 8'b0111_1110);
  assign abort_ev = mon.MonEN && (window == 8'b0111_1111);
  assign stuff_ev = mon.MonEN && (state_q == ST_FRAME) && (window[6:0] == 7'b011_1110);

  assign miss_flag  = fpipe_q[FLAG_LAT-1] && !mon.Rx_FlagDetect;
  assign spur_flag  = mon.Rx_FlagDetect && !fpipe_q[FLAG_LAT-1];
  assign miss_abort = apipe_q[ABORT_LAT-1] && !mon.Rx_AbortDetect;
  assign spur_abort = mon.Rx_AbortDetect && !apipe_q[ABORT_LAT-1];

`ifdef HDLC_MON_IDLE_CHECK_EN
  assign idle_err = mon.Rx_ValidFrame && (state_q == ST_IDLE);
`else
  logic unused_valid_frame;
  assign unused_valid_frame = mon.Rx_ValidFrame;
  assign idle_err           = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (clr)
      return '0;
    else if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    else
      return c;
  endfunction

  always_comb begin
    hist_d  = hist_q;
    ones_d  = ones_q;
    state_d = state_q;
    if (mon.MonEN) begin
      hist_d = window;
      if (!mon.Rx)
        ones_d = 5'd0;
      else if (ones_q != IDLE_MAX)
        ones_d = ones_q + 5'd1;

      if (ones_d == IDLE_MAX)
        state_d = ST_IDLE;
      else if (abort_ev)
        state_d = ST_ABORT;
      else if (flag_ev)
        state_d = ST_FLAG;
      else if ((state_q == ST_FLAG) && mon.Rx)
        // a 0 right after a flag may be the opening zero of the next flag
        state_d = ST_FRAME;
    end
  end

  always_comb begin
    fpipe_d    = fpipe_q << 1;
    fpipe_d[0] = flag_ev;
    apipe_d    = apipe_q << 1;
    apipe_d[0] = abort_ev;

    err_d      = 1'b0;
    err_code_d = err_code_q;
    if (miss_flag) begin
      err_d = 1'b1; err_code_d = 3'd1;
    end else if (spur_flag) begin
      err_d = 1'b1; err_code_d = 3'd2;
    end else if (miss_abort) begin
      err_d = 1'b1; err_code_d = 3'd3;
    end else if (spur_abort) begin
      err_d = 1'b1; err_code_d = 3'd4;
    end else if (idle_err) begin
      err_d = 1'b1; err_code_d = 3'd5;
    end

    flag_cnt_d  = cnt_next(flag_cnt_q,  flag_ev,  mon.Clr);
    abort_cnt_d = cnt_next(abort_cnt_q, abort_ev, mon.Clr);
    stuff_cnt_d = cnt_next(stuff_cnt_q, stuff_ev, mon.Clr);
    err_cnt_d   = cnt_next(err_cnt_q,   err_d,    mon.Clr);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      hist_q      <= 8'hFF;
      ones_q      <= 5'd0;
      fpipe_q     <= '0;
      apipe_q     <= '0;
      flag_cnt_q  <= '0;
      abort_cnt_q <= '0;
      stuff_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      ones_q      <= ones_d;
      fpipe_q     <= fpipe_d;
      apipe_q     <= apipe_d;
      flag_cnt_q  <= flag_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      stuff_cnt_q <= stuff_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mon.FlagCnt   = flag_cnt_q;
  assign mon.AbortCnt  = abort_cnt_q;
  assign mon.StuffCnt  = stuff_cnt_q;
  assign mon.ErrCnt    = err_cnt_q;
  assign mon.Err       = err_q;
  assign mon.ErrCode   = err_code_q;
  assign mon.LineState = state_q;

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb/tb_hdlc_line_monitor.sv - directed self-checking bench for hdlc_line_monitor
module tb_hdlc_line_monitor;
  localparam int CNT_W = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  hdlc_line_monitor_if #(.CNT_W(CNT_W)) mon ();

  hdlc_line_monitor #(
    .CNT_W(CNT_W), .FLAG_LAT(2), .ABORT_LAT(2), .IDLE_LEN(15)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .mon(mon)
  );

  always #5 Clk = ~Clk;

  int         checks    = 0;
  int         failures  = 0;
  int         err_seen  = 0;
  logic [2:0] last_code = 3'd0;

  // Err is high for one full period, so the mid-period edge sees each pulse once.
  always @(negedge Clk) begin
    if (mon.Err === 1'b1) begin
      err_seen  = err_seen + 1;
      last_code = mon.ErrCode;
    end
  end

  task automatic cyc(input logic rx, input logic fd, input logic ad);
    mon.Rx             = rx;
    mon.Rx_FlagDetect  = fd;
    mon.Rx_AbortDetect = ad;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_flag_bits();
    cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic flag_ok();
    send_flag_bits();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    Rst                = 1'b0;
    mon.MonEN          = 1'b1;
    mon.Clr            = 1'b0;
    mon.Rx             = 1'b1;
    mon.Rx_ValidFrame  = 1'b0;
    mon.Rx_FlagDetect  = 1'b0;
    mon.Rx_AbortDetect = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst      = 1'b1;
    err_seen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mon.LineState !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", mon.LineState); end
    checks++; if (mon.FlagCnt !== 4'd0) begin failures++; $display("FAIL reset_flagcnt got=%0d exp=0", mon.FlagCnt); end
    checks++; if (mon.AbortCnt !== 4'd0) begin failures++; $display("FAIL reset_abortcnt got=%0d exp=0", mon.AbortCnt); end
    checks++; if (mon.StuffCnt !== 4'd0) begin failures++; $display("FAIL reset_stuffcnt got=%0d exp=0", mon.StuffCnt); end
    checks++; if (mon.ErrCnt !== 4'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", mon.ErrCnt); end
    checks++; if (mon.Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", mon.Err); end
  endtask

  task automatic test_flag_ok();
    do_reset();
    send_flag_bits();
    checks++; if (mon.LineState !== 2'd1) begin failures++; $display("FAIL flag_ok_state got=%0d exp=1", mon.LineState); end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    idle(3);
    checks++; if (mon.FlagCnt !== 4'd1) begin failures++; $display("FAIL flag_ok_cnt got=%0d exp=1", mon.FlagCnt); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL flag_ok_noerr got=%0d exp=0", err_seen); end
  endtask

  task automatic test_flag_missing();
    do_reset();
    send_flag_bits();
    idle(5);
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL flag_miss_pulses got=%0d exp=1", err_seen); end
    checks++; if (last_code !== 3'd1) begin failures++; $display("FAIL flag_miss_code got=%0d exp=1", last_code); end
    checks++; if (mon.ErrCnt !== 4'd1) begin failures++; $display("FAIL flag_miss_errcnt got=%0d exp=1", mon.ErrCnt); end
  endtask

  task automatic test_stuff();
    do_reset();
    flag_ok();
    cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    flag_ok();
    idle(2);
    checks++; if (mon.StuffCnt !== 4'd1) begin failures++; $display("FAIL stuff_cnt got=%0d exp=1", mon.StuffCnt); end
    checks++; if (mon.FlagCnt !== 4'd2) begin failures++; $display("FAIL stuff_flagcnt got=%0d exp=2", mon.FlagCnt); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL stuff_noerr got=%0d exp=0", err_seen); end
  endtask

  task automatic test_abort();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (mon.LineState !== 2'd3) begin failures++; $display("FAIL abort_state got=%0d exp=3", mon.LineState); end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    idle(4);
    checks++; if (mon.AbortCnt !== 4'd1) begin failures++; $display("FAIL abort_cnt got=%0d exp=1", mon.AbortCnt); end
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL abort_pulses got=%0d exp=1", err_seen); end
    checks++; if (last_code !== 3'd2) begin failures++; $display("FAIL abort_code got=%0d exp=2", last_code); end
    checks++; if (mon.ErrCnt !== 4'd1) begin failures++; $display("FAIL abort_errcnt got=%0d exp=1", mon.ErrCnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    idle(2);
    checks++; if (err_seen !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", err_seen); end
    checks++; if (mon.ErrCode !== 3'd4) begin failures++; $display("FAIL b2b_code_hold got=%0d exp=4", mon.ErrCode); end
    checks++; if (mon.ErrCnt !== 4'd2) begin failures++; $display("FAIL b2b_errcnt got=%0d exp=2", mon.ErrCnt); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    send_flag_bits();
    do_reset();
    idle(4);
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL rst_pend_noerr got=%0d exp=0", err_seen); end
    checks++; if (mon.ErrCode !== 3'd0) begin failures++; $display("FAIL rst_pend_code got=%0d exp=0", mon.ErrCode); end
    checks++; if (mon.FlagCnt !== 4'd0) begin failures++; $display("FAIL rst_pend_flagcnt got=%0d exp=0", mon.FlagCnt); end
  endtask

  task automatic test_monen();
    do_reset();
    send_flag_bits();
    mon.MonEN = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (mon.LineState !== 2'd1) begin failures++; $display("FAIL monen_frozen got=%0d exp=1", mon.LineState); end
    send_flag_bits();
    idle(4);
    mon.MonEN = 1'b1;
    checks++; if (mon.FlagCnt !== 4'd1) begin failures++; $display("FAIL monen_flagcnt got=%0d exp=1", mon.FlagCnt); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL monen_noerr got=%0d exp=0", err_seen); end
  endtask

  task automatic test_saturate_clr();
    do_reset();
    repeat (20) flag_ok();
    checks++; if (mon.FlagCnt !== 4'd15) begin failures++; $display("FAIL sat_flagcnt got=%0d exp=15", mon.FlagCnt); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL sat_noerr got=%0d exp=0", err_seen); end
    cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    mon.Clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    mon.Clr = 1'b0;
    checks++; if (mon.FlagCnt !== 4'd0) begin failures++; $display("FAIL clr_flagcnt got=%0d exp=0", mon.FlagCnt); end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    idle(3);
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL clr_noerr got=%0d exp=0", err_seen); end
    checks++; if (mon.FlagCnt !== 4'd0) begin failures++; $display("FAIL clr_hold got=%0d exp=0", mon.FlagCnt); end
  endtask

  task automatic test_idle_check();
    do_reset();
    idle(15);
    mon.Rx_ValidFrame = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    mon.Rx_ValidFrame = 1'b0;
    idle(3);
`ifdef HDLC_MON_IDLE_CHECK_EN
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL idle_chk_pulses got=%0d exp=1", err_seen); end
    checks++; if (last_code !== 3'd5) begin failures++; $display("FAIL idle_chk_code got=%0d exp=5", last_code); end
`else
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL idle_chk_noerr got=%0d exp=0", err_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_flag_ok();
    test_flag_missing();
    test_stuff();
    test_abort();
    test_back_to_back();
    test_reset_pending();
    test_monen();
    test_saturate_clr();
    test_idle_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
